// File: rtl/imem_loader.sv
// Boot loader: takes a length-prefixed, XOR-checksummed byte stream, writes little-endian
// words into instruction memory, then releases the core once the checksum matches.
module imem_loader #(
  parameter int unsigned ADDR_W = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rx_valid,
  input  logic [7:0]        rx_data,
  output logic              rx_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              core_run,
  output logic              done,
  output logic              error
);

  localparam int unsigned Cap = 1 << ADDR_W;

  typedef enum logic [2:0] {
    StLenLo,
    StLenHi,
    StData,
    StChk,
    StRun,
    StErr
  } state_e;

  state_e            state_q, state_d;
  logic [7:0]        len_lo_q, len_lo_d;
  logic [ADDR_W:0]   len_q, len_d;
  logic [ADDR_W:0]   cnt_q, cnt_d;
  logic [1:0]        idx_q, idx_d;
  logic [7:0]        csum_q, csum_d;
  logic [23:0]       word_q, word_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [31:0]       n_len;
  logic [ADDR_W:0]   cnt_inc;

  // Decode of the registered state only; no path from rx_valid.
  assign rx_ready  = (state_q != StRun) && (state_q != StErr);
  assign core_run  = (state_q == StRun);
  assign done      = (state_q == StRun);
  assign error     = (state_q == StErr);
  assign mem_we    = we_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;

  always_comb begin
    state_d  = state_q;
    len_lo_d = len_lo_q;
    len_d    = len_q;
    cnt_d    = cnt_q;
    idx_d    = idx_q;
    csum_d   = csum_q;
    word_d   = word_q;
    we_d     = 1'b0;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    n_len    = {16'h0000, rx_data, len_lo_q};
    cnt_inc  = cnt_q + {{ADDR_W{1'b0}}, 1'b1};

    if (rx_valid && rx_ready) begin
      unique case (state_q)
        StLenLo: begin
          len_lo_d = rx_data;
          state_d  = StLenHi;
        end
        StLenHi: begin
          len_d = n_len[ADDR_W:0];
          if (n_len > Cap) begin
            state_d = StErr;
          end else if (n_len == 32'd0) begin
            state_d = StChk;
          end else begin
            state_d = StData;
          end
        end
        StData: begin
          csum_d = csum_q ^ rx_data;
          idx_d  = idx_q + 2'd1;
          // Bytes arrive LSB first, so shift right and land the 4th byte on top.
          word_d = {rx_data, word_q[23:8]};
          if (idx_q == 2'd3) begin
            we_d    = 1'b1;
            addr_d  = cnt_q[ADDR_W-1:0];
            wdata_d = {rx_data, word_q};
            cnt_d   = cnt_inc;
            if (cnt_inc == len_q) begin
              state_d = StChk;
            end
          end
        end
        StChk: begin
          state_d = (rx_data == csum_q) ? StRun : StErr;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= StLenLo;
      len_lo_q <= '0;
      len_q    <= '0;
      cnt_q    <= '0;
      idx_q    <= '0;
      csum_q   <= '0;
      word_q   <= '0;
      we_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
    end else begin
      state_q  <= state_d;
      len_lo_q <= len_lo_d;
      len_q    <= len_d;
      cnt_q    <= cnt_d;
      idx_q    <= idx_d;
      csum_q   <= csum_d;
      word_q   <= word_d;
      we_q     <= we_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Bench for imem_loader: a byte-index model predicts every output each cycle; literal
// checks pin the write log and final status of each directed scenario.
module tb_imem_loader;

  localparam int unsigned ADDR_W = 10;
  localparam int unsigned CAP = 1 << ADDR_W;

  logic              clk = 1'b0;
  logic              rst;
  logic              rx_valid;
  logic [7:0]        rx_data;
  logic              rx_ready;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic              core_run;
  logic              done;
  logic              error;

  imem_loader #(.ADDR_W(ADDR_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .rx_valid  (rx_valid),
    .rx_data   (rx_data),
    .rx_ready  (rx_ready),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .core_run  (core_run),
    .done      (done),
    .error     (error)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: position of each accepted byte in the stream decides what it means.
  int          m_cnt;
  int          m_n;
  int          m_status;   // 0 loading, 1 run, 2 error
  logic [7:0]  m_lo;
  logic [7:0]  m_xor;
  logic [31:0] m_word;
  logic        exp_we;
  int          exp_addr;
  logic [31:0] exp_wdata;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_cnt = 0; m_n = 0; m_status = 0; m_lo = 0; m_xor = 0; m_word = 0;
      exp_we = 0; exp_addr = 0; exp_wdata = 0;
    end else begin
      int k;
      int p;
      exp_we = 0;
      if (m_status == 0 && rx_valid) begin
        k = m_cnt;
        m_cnt++;
        if (k == 0) begin
          m_lo = rx_data;
        end else if (k == 1) begin
          m_n = {rx_data, m_lo};
          if (m_n > CAP) m_status = 2;
        end else if (k - 2 < 4 * m_n) begin
          p = k - 2;
          m_word[8*(p%4) +: 8] = rx_data;
          m_xor = m_xor ^ rx_data;
          if (p % 4 == 3) begin
            exp_we = 1; exp_addr = p / 4; exp_wdata = m_word;
          end
        end else begin
          m_status = (rx_data == m_xor) ? 1 : 2;
        end
      end
    end
  end

  logic [31:0] log_data[$];
  int          log_addr[$];

  always @(negedge clk) begin
    chk("rx_ready", 32'(rx_ready), 32'(m_status == 0));
    chk("mem_we", 32'(mem_we), 32'(exp_we));
    chk("core_run", 32'(core_run), 32'(m_status == 1));
    chk("done", 32'(done), 32'(m_status == 1));
    chk("error", 32'(error), 32'(m_status == 2));
    if (exp_we || !rst) begin
      chk("mem_addr", 32'(mem_addr), 32'(exp_addr));
      chk("mem_wdata", mem_wdata, exp_wdata);
    end
    if (rst && mem_we) begin
      log_data.push_back(mem_wdata);
      log_addr.push_back(int'(mem_addr));
    end
  end

  logic [7:0] stream[$];

  task automatic two_word(input logic [7:0] csum);
    stream = {8'h02, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12, 8'hEF, 8'hBE, 8'hAD, 8'hDE, csum};
  endtask

  task automatic build_words(input int n);
    logic [7:0]  x;
    logic [31:0] w;
    x = 8'h00;
    stream = {};
    stream.push_back(n[7:0]);
    stream.push_back(n[15:8]);
    for (int i = 0; i < n; i++) begin
      w = 32'h9E3779B9 * (i + 1);
      for (int b = 0; b < 4; b++) begin
        stream.push_back(w[8*b +: 8]);
        x = x ^ w[8*b +: 8];
      end
    end
    stream.push_back(x);
  endtask

  task automatic send(input int count, input int gapmax);
    int tries;
    int g;
    for (int i = 0; i < count && i < stream.size(); i++) begin
      g = (gapmax > 0) ? int'($urandom_range(gapmax, 0)) : 0;
      repeat (g) begin
        rx_valid = 1'b0;
        @(posedge clk); #1;
      end
      rx_valid = 1'b1;
      rx_data  = stream[i];
      tries = 0;
      while (!rx_ready && tries < 20) begin
        @(posedge clk); #1;
        tries++;
      end
      if (!rx_ready) begin
        checks++; errors++;
        $display("FAIL accept: byte %0d refused, rx_ready %b expected 1", i, rx_ready);
        break;
      end
      @(posedge clk); #1;
    end
    rx_valid = 1'b0;
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    log_data = {};
    log_addr = {};
  endtask

  task automatic settle();
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic check_two_word_log(input string tag);
    chk({tag, "_nwrites"}, 32'(log_data.size()), 32'd2);
    if (log_data.size() == 2) begin
      chk({tag, "_w0"}, log_data[0], 32'h12345678);
      chk({tag, "_a0"}, 32'(log_addr[0]), 32'd0);
      chk({tag, "_w1"}, log_data[1], 32'hDEADBEEF);
      chk({tag, "_a1"}, 32'(log_addr[1]), 32'd1);
    end
  endtask

  initial begin
    rst = 1'b0;
    rx_valid = 1'b0;
    rx_data = 8'h00;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_rx_ready", 32'(rx_ready), 32'd1);
    chk("reset_mem_we", 32'(mem_we), 32'd0);
    chk("reset_core_run", 32'(core_run), 32'd0);
    rst = 1'b1;

    // Two-word load; the XOR of the eight payload bytes works out to 0x2A.
    two_word(8'h2A);
    send(stream.size(), 0);
    settle();
    check_two_word_log("two");
    chk("two_done", 32'(done), 32'd1);
    chk("two_core_run", 32'(core_run), 32'd1);
    chk("model_xor", 32'(m_xor), 32'h2A);

    // Zero length.
    do_reset();
    stream = {8'h00, 8'h00, 8'h00};
    send(3, 0);
    settle();
    chk("zero_nwrites", 32'(log_data.size()), 32'd0);
    chk("zero_done", 32'(done), 32'd1);

    // Bad checksum, then an extra byte that must be refused.
    do_reset();
    two_word(8'h01);
    send(stream.size(), 0);
    rx_valid = 1'b1;
    rx_data = 8'h55;
    settle();
    rx_valid = 1'b0;
    check_two_word_log("bad");
    chk("bad_error", 32'(error), 32'd1);
    chk("bad_core_run", 32'(core_run), 32'd0);
    chk("bad_rx_ready", 32'(rx_ready), 32'd0);

    // Oversize: N = 1025.
    do_reset();
    stream = {8'h01, 8'h04};
    send(2, 0);
    settle();
    chk("over_nwrites", 32'(log_data.size()), 32'd0);
    chk("over_error", 32'(error), 32'd1);

    // Exactly full: N = 1024.
    do_reset();
    build_words(1024);
    send(stream.size(), 0);
    settle();
    chk("full_nwrites", 32'(log_data.size()), 32'd1024);
    if (log_data.size() == 1024) begin
      chk("full_last_addr", 32'(log_addr[1023]), 32'd1023);
      chk("full_first_word", log_data[0], 32'h9E3779B9);
    end
    chk("full_done", 32'(done), 32'd1);

    // Random gaps in rx_valid.
    do_reset();
    two_word(8'h2A);
    send(stream.size(), 5);
    settle();
    check_two_word_log("gap");
    chk("gap_done", 32'(done), 32'd1);

    // Reset after the 5th payload byte, then a fresh load.
    do_reset();
    two_word(8'h2A);
    send(7, 0);
    rst = 1'b0;
    #1;
    chk("midrst_rx_ready", 32'(rx_ready), 32'd1);
    chk("midrst_mem_we", 32'(mem_we), 32'd0);
    chk("midrst_mem_addr", 32'(mem_addr), 32'd0);
    chk("midrst_mem_wdata", mem_wdata, 32'd0);
    chk("midrst_done", 32'(done), 32'd0);
    chk("midrst_error", 32'(error), 32'd0);
    @(posedge clk); #1;
    rst = 1'b1;
    log_data = {};
    log_addr = {};
    send(stream.size(), 0);
    settle();
    check_two_word_log("rerun");
    chk("rerun_done", 32'(done), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
